// File: rtl/ibus_dbus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ibus_dbus_arbiter_pkg
// Shared encodings for the instruction/data bus arbiter:
//   - arb_state_e  : 3-bit FSM state encoding
//   - RST_ENABLE   : active level of the synchronous reset
//   - CHIP_ENABLE  : active level of if_ce / mem_ce
//   - STOP/NO_STOP : levels of a pipeline stall bit
//   - STALL_W / STALL_IF_ID : stall vector width and the IF/ID hold bit
// The NOP / zero word is all-zero at any data width and is written as '0.
// -----------------------------------------------------------------------------
package ibus_dbus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MEM_BUSY   = 3'd1,
    ST_MEM_DONE   = 3'd2,
    ST_IF_BUSY    = 3'd3,
    ST_IF_DISCARD = 3'd4,
    ST_IF_WAIT    = 3'd5
  } arb_state_e;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;

  localparam int STALL_W     = 6;
  localparam int STALL_IF_ID = 1;

  // True when the pipeline controller is holding the IF/ID register.
  function automatic logic if_id_held(input logic [STALL_W-1:0] stall_vec);
    return stall_vec[STALL_IF_ID] == STOP;
  endfunction

endpackage

// File: rtl/ibus_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// ibus_dbus_arbiter
// Shares one req/ack memory bus between instruction fetch and the MEM-stage
// load/store port. MEM wins when both ask in the same IDLE cycle; a bus cycle,
// once started, is never preempted and its address/data stay stable until ack.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   stall[5:0]     : pipeline stall vector (bit 1 = IF/ID hold)
//   flush          : exception flush, one-cycle pulse
//   if_ce/if_addr  : fetch request and PC          -> if_inst, stallreq_if
//   mem_ce/we/sel/addr/wdata : MEM-stage access    -> mem_rdata, stallreq_mem
//   bus_req/we/sel/addr/wdata: registered bus master outputs
//   bus_rdata/bus_ack        : slave response, ack latency >= 1 cycle
// -----------------------------------------------------------------------------
module ibus_dbus_arbiter
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  // instruction fetch port
  input  logic                if_ce,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_inst,
  output logic                stallreq_if,
  // MEM-stage data port
  input  logic                mem_ce,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_mem,
  // external memory bus
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack
);

  arb_state_e          state_q;
  logic                bus_req_q;
  logic                bus_we_q;
  logic [DATA_W/8-1:0] bus_sel_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic [DATA_W-1:0]   inst_q;       // instruction held while IF/ID is stalled

  logic mem_go;
  logic if_go;
  logic if_hold;

  assign mem_go  = (mem_ce == CHIP_ENABLE) && !flush;
  assign if_go   = (if_ce  == CHIP_ENABLE) && !flush;
  assign if_hold = if_id_held(stall);

  // Only the IF/ID hold bit matters here; the rest of the vector is ignored.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:STALL_IF_ID+1], stall[STALL_IF_ID-1:0]};

  // State and every registered output live in one block so the bus outputs
  // change on exactly the edges that enter or leave a BUSY state.
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      // An in-flight cycle is abandoned here; dropping bus_req is the abort.
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_rdata_q <= '0;
      inst_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_go) begin
            state_q     <= ST_MEM_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_sel_q   <= mem_sel;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
          end else if (if_go) begin
            state_q     <= ST_IF_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '1;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
          end
        end

        ST_MEM_BUSY: begin
          if (bus_ack) begin
            state_q     <= ST_MEM_DONE;
            // Stores return nothing useful; present zero to the pipeline.
            mem_rdata_q <= bus_we_q ? '0 : bus_rdata;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
          end
        end

        // One cycle with stallreq_mem low so the MEM stage can advance.
        ST_MEM_DONE: state_q <= ST_IDLE;

        ST_IF_BUSY: begin
          if (bus_ack) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if (!flush && if_hold) begin
              state_q <= ST_IF_WAIT;
              inst_q  <= bus_rdata;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (flush) begin
            // The slave still owes an ack; finish the cycle and drop the data.
            state_q <= ST_IF_DISCARD;
          end
        end

        ST_IF_DISCARD: begin
          if (bus_ack) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
          end
        end

        ST_IF_WAIT: begin
          if (flush) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
          end else if (stall[STALL_IF_ID] == NO_STOP) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The fetched word bypasses the register on an unstalled ack so IF/ID can
  // capture it on the same edge the bus cycle ends.
  // NOTE: always_comb gets a default first so no path leaves if_inst
  // unassigned, which would infer a latch.
  always_comb begin
    if_inst = '0;
    if (state_q == ST_IF_BUSY && bus_ack && !flush) begin
      if_inst = bus_rdata;
    end else if (state_q == ST_IF_WAIT) begin
      if_inst = inst_q;
    end
  end

  assign stallreq_if  = (if_ce == CHIP_ENABLE) && !flush
                      && !(state_q == ST_IF_BUSY && bus_ack)
                      && (state_q != ST_IF_WAIT);
  assign stallreq_mem = (mem_ce == CHIP_ENABLE) && (state_q != ST_MEM_DONE);

  assign mem_rdata = mem_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ibus_dbus_arbiter
// Directed scenarios against a behavioural slave with programmable ack
// latency. Expected bus transactions are queued as requests are driven and
// checked by a monitor when the DUT starts each bus cycle; per-scenario
// outputs are compared inline.
// -----------------------------------------------------------------------------
module tb_ibus_dbus_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int checks   = 0;
  int failures = 0;
  int ack_lat  = 1;

  bus_txn_t exp_bus_q[$];

  always #5 clk = ~clk;

  ibus_dbus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_ce(if_ce), .if_addr(if_addr), .if_inst(if_inst), .stallreq_if(stallreq_if),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  // Slave memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return 32'h3C01_1230 ^ a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural slave: acks in the ack_lat-th cycle of bus_req.
  initial begin
    int cnt;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_req === 1'b1) begin
        cnt++;
        if (cnt >= ack_lat) begin
          bus_ack = 1'b1;
          bus_rdata = mem_model(bus_addr);
        end else begin
          bus_ack = 1'b0;
          bus_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        cnt = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Bus monitor: pops the expected transaction when a cycle starts and
  // requires the request fields to stay stable while bus_req is held.
  initial begin
    logic     prev_req;
    bus_txn_t cur;
    prev_req = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1 && !prev_req) begin
        checks++;
        if (exp_bus_q.size() == 0) begin
          failures++;
          $display("FAIL bus_unexpected got addr=%08h exp=no cycle", bus_addr);
        end else begin
          cur = exp_bus_q.pop_front();
          checks++;
          if ({bus_we, bus_sel, bus_addr, bus_wdata} !== cur) begin
            failures++;
            $display("FAIL bus_txn got we=%0b sel=%h addr=%08h wdata=%08h exp we=%0b sel=%h addr=%08h wdata=%08h",
                     bus_we, bus_sel, bus_addr, bus_wdata, cur.we, cur.sel, cur.addr, cur.wdata);
          end
        end
      end else if (bus_req === 1'b1 && prev_req) begin
        checks++;
        if ({bus_we, bus_sel, bus_addr, bus_wdata} !== cur) begin
          failures++;
          $display("FAIL bus_stable got addr=%08h wdata=%08h exp addr=%08h wdata=%08h",
                   bus_addr, bus_wdata, cur.addr, cur.wdata);
        end
      end
      prev_req = (bus_req === 1'b1);
    end
  end

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0;
    if_ce = 1'b0; if_addr = '0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%0b exp=0", bus_req); end
    checks++; if ({bus_we, bus_sel, bus_addr, bus_wdata} !== '0) begin failures++; $display("FAIL reset_bus_fields got addr=%08h exp=0", bus_addr); end
    checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_if_inst got=%08h exp=0", if_inst); end
    checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_mem_rdata got=%08h exp=0", mem_rdata); end
    checks++; if ({stallreq_if, stallreq_mem} !== 2'b00) begin failures++; $display("FAIL reset_stallreq got=%b exp=00", {stallreq_if, stallreq_mem}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    ack_lat = 2;
    tick();
    if_ce = 1'b1; if_addr = 32'h0000_0004;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h4, wdata: 32'h0});
    @(negedge clk);
    checks++; if (stallreq_if !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0 got=%0b exp=1", stallreq_if); end
    tick();
    @(negedge clk);
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h4) begin failures++; $display("FAIL fetch_req got req=%0b addr=%08h exp req=1 addr=00000004", bus_req, bus_addr); end
    checks++; if (stallreq_if !== 1'b1 || if_inst !== 32'h0) begin failures++; $display("FAIL fetch_wait got stall=%0b inst=%08h exp stall=1 inst=0", stallreq_if, if_inst); end
    tick();
    @(negedge clk);
    checks++; if (if_inst !== 32'h3C01_1234) begin failures++; $display("FAIL fetch_inst got=%08h exp=3c011234", if_inst); end
    checks++; if (stallreq_if !== 1'b0) begin failures++; $display("FAIL fetch_ack_stall got=%0b exp=0", stallreq_if); end
    tick();
    if_ce = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || if_inst !== 32'h0) begin failures++; $display("FAIL fetch_idle got req=%0b inst=%08h exp req=0 inst=0", bus_req, if_inst); end
  endtask

  task automatic test_mem_priority();
    ack_lat = 1;
    tick();
    if_ce = 1'b1; if_addr = 32'h0000_0008;
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0100; mem_wdata = '0;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h100, wdata: 32'h0});
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h8,   wdata: 32'h0});
    @(negedge clk);
    checks++; if ({stallreq_if, stallreq_mem} !== 2'b11) begin failures++; $display("FAIL prio_stall_c0 got=%b exp=11", {stallreq_if, stallreq_mem}); end
    tick();
    @(negedge clk);
    checks++; if ({stallreq_if, stallreq_mem} !== 2'b11) begin failures++; $display("FAIL prio_stall_busy got=%b exp=11", {stallreq_if, stallreq_mem}); end
    tick();
    @(negedge clk);
    checks++; if (mem_rdata !== mem_model(32'h100)) begin failures++; $display("FAIL prio_mem_rdata got=%08h exp=%08h", mem_rdata, mem_model(32'h100)); end
    checks++; if ({stallreq_if, stallreq_mem, bus_req} !== 3'b100) begin failures++; $display("FAIL prio_mem_done got if/mem/req=%b exp=100", {stallreq_if, stallreq_mem, bus_req}); end
    tick();
    mem_ce = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || stallreq_if !== 1'b1) begin failures++; $display("FAIL prio_idle got req=%0b stall=%0b exp req=0 stall=1", bus_req, stallreq_if); end
    tick();
    @(negedge clk);
    checks++; if (if_inst !== mem_model(32'h8) || stallreq_if !== 1'b0) begin failures++; $display("FAIL prio_fetch got inst=%08h stall=%0b exp inst=%08h stall=0", if_inst, stallreq_if, mem_model(32'h8)); end
    tick();
    if_ce = 1'b0;
  endtask

  task automatic test_reset_mid();
    ack_lat = 100;
    tick();
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0300; mem_wdata = '0;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h300, wdata: 32'h0});
    tick();
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%0b exp=1", bus_req); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ce = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin failures++; $display("FAIL rstmid_bus got req=%0b addr=%08h exp req=0 addr=0", bus_req, bus_addr); end
    checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_mem_rdata got=%08h exp=0", mem_rdata); end
    tick();
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || stallreq_mem !== 1'b0) begin failures++; $display("FAIL rstmid_idle got req=%0b stall=%0b exp 0 0", bus_req, stallreq_mem); end
  endtask

  task automatic test_if_wait();
    ack_lat = 1;
    tick();
    if_ce = 1'b1; if_addr = 32'h0000_0010; stall = 6'b000000;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h10, wdata: 32'h0});
    tick();
    stall = 6'b000010;
    @(negedge clk);
    checks++; if (if_inst !== mem_model(32'h10) || stallreq_if !== 1'b0) begin failures++; $display("FAIL wait_ack got inst=%08h stall=%0b exp inst=%08h stall=0", if_inst, stallreq_if, mem_model(32'h10)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++; if (if_inst !== mem_model(32'h10) || stallreq_if !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL wait_hold%0d got inst=%08h stall=%0b req=%0b exp inst=%08h stall=0 req=0", i, if_inst, stallreq_if, bus_req, mem_model(32'h10)); end
    end
    tick();
    stall = 6'b000000;
    @(negedge clk);
    checks++; if (if_inst !== mem_model(32'h10)) begin failures++; $display("FAIL wait_release got=%08h exp=%08h", if_inst, mem_model(32'h10)); end
    tick();
    if_ce = 1'b0;
    @(negedge clk);
    checks++; if (if_inst !== 32'h0 || bus_req !== 1'b0) begin failures++; $display("FAIL wait_idle got inst=%08h req=%0b exp inst=0 req=0", if_inst, bus_req); end
    // Flush while holding: the held word is thrown away.
    tick();
    if_ce = 1'b1; if_addr = 32'h0000_0014;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h14, wdata: 32'h0});
    tick();
    stall = 6'b000010;
    tick();
    @(negedge clk);
    checks++; if (if_inst !== mem_model(32'h14)) begin failures++; $display("FAIL wflush_hold got=%08h exp=%08h", if_inst, mem_model(32'h14)); end
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (stallreq_if !== 1'b0) begin failures++; $display("FAIL wflush_stall got=%0b exp=0", stallreq_if); end
    tick();
    flush = 1'b0; stall = 6'b000000; if_ce = 1'b0;
    @(negedge clk);
    checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL wflush_discard got=%08h exp=0", if_inst); end
  endtask

  task automatic test_flush_discard();
    ack_lat = 3;
    tick();
    if_ce = 1'b1; if_addr = 32'h0000_0020;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h20, wdata: 32'h0});
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (if_inst !== 32'h0 || stallreq_if !== 1'b0 || bus_req !== 1'b1) begin failures++; $display("FAIL disc_flush got inst=%08h stall=%0b req=%0b exp 0 0 1", if_inst, stallreq_if, bus_req); end
    tick();
    flush = 1'b0; if_addr = 32'h0000_0040;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1 || if_inst !== 32'h0 || stallreq_if !== 1'b1) begin failures++; $display("FAIL disc_wait got req=%0b inst=%08h stall=%0b exp 1 0 1", bus_req, if_inst, stallreq_if); end
    tick();
    @(negedge clk);
    checks++; if (bus_ack !== 1'b1 || if_inst !== 32'h0 || stallreq_if !== 1'b1) begin failures++; $display("FAIL disc_ack got ack=%0b inst=%08h stall=%0b exp 1 0 1", bus_ack, if_inst, stallreq_if); end
    tick();
    ack_lat = 1;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h40, wdata: 32'h0});
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL disc_idle got=%0b exp=0", bus_req); end
    tick();
    @(negedge clk);
    checks++; if (if_inst !== mem_model(32'h40)) begin failures++; $display("FAIL disc_refetch got=%08h exp=%08h", if_inst, mem_model(32'h40)); end
    // Flush coinciding with ack drops the word immediately.
    tick();
    if_addr = 32'h0000_0050;
    exp_bus_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h50, wdata: 32'h0});
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (bus_ack !== 1'b1 || if_inst !== 32'h0) begin failures++; $display("FAIL flush_ack got ack=%0b inst=%08h exp ack=1 inst=0", bus_ack, if_inst); end
    tick();
    flush = 1'b0; if_ce = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || if_inst !== 32'h0) begin failures++; $display("FAIL flush_ack_idle got req=%0b inst=%08h exp 0 0", bus_req, if_inst); end
  endtask

  task automatic test_store();
    ack_lat = 3;
    tick();
    mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h0000_0200; mem_wdata = 32'hDEAD_BEEF;
    exp_bus_q.push_back('{we: 1'b1, sel: 4'b0011, addr: 32'h200, wdata: 32'hDEAD_BEEF});
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++; if ({bus_req, bus_we, bus_sel, bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF}) begin failures++; $display("FAIL store_hold%0d got req=%0b we=%0b sel=%b wdata=%08h exp 1 1 0011 deadbeef", i, bus_req, bus_we, bus_sel, bus_wdata); end
      checks++; if (stallreq_mem !== 1'b1) begin failures++; $display("FAIL store_stall%0d got=%0b exp=1", i, stallreq_mem); end
    end
    tick();
    @(negedge clk);
    checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL store_rdata got=%08h exp=0", mem_rdata); end
    checks++; if ({stallreq_mem, bus_req, bus_we, bus_sel} !== 7'b0) begin failures++; $display("FAIL store_done got stall=%0b req=%0b we=%0b sel=%b exp all 0", stallreq_mem, bus_req, bus_we, bus_sel); end
    tick();
    mem_ce = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_mem_priority();
    test_reset_mid();
    test_if_wait();
    test_flush_discard();
    test_store();
    tick();
    @(negedge clk);
    checks++;
    if (exp_bus_q.size() != 0) begin
      failures++;
      $display("FAIL bus_leftover got=%0d exp=0", exp_bus_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibus_dbus_arbiter.md
Name: ibus_dbus_arbiter

Overview:
- Shares the single external memory bus between two requesters.
  - Instruction fetch: address driven by the PC register.
  - MEM-stage load/store.
- Drives the bus with a req/ack handshake and raises per-requester stall requests toward the pipeline controller, so the PC and pipeline registers hold while a transfer is outstanding.
- Handles pipeline stall and exception flush arriving during an in-flight fetch.
- Sits between the IF/MEM stages and the memory slave.

Parameters:
- ADDR_W, 32, bus/PC address width
- DATA_W, 32, bus data width; byte-select width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  6  stall vector from pipeline controller; bit1 = IF/ID hold
- flush  in  1  exception flush; one-cycle pulse
- if_ce  in  1  fetch enable (PC chip-enable)
- if_addr  in  ADDR_W  fetch address (current PC)
- if_inst  out  DATA_W  fetched instruction to IF/ID
- stallreq_if  out  1  fetch not yet complete
- mem_ce  in  1  MEM-stage access request
- mem_we  in  1  1 = store
- mem_sel  in  DATA_W/8  byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data
- stallreq_mem  out  1  data access not yet complete
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write
- bus_sel  out  DATA_W/8  bus byte enables
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_rdata  in  DATA_W  bus read data; valid when bus_ack=1
- bus_ack  in  1  transfer complete; any latency >= 1 cycle

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state: IDLE. All bus_* outputs = 0; if_inst = 0 (NOP); mem_rdata = 0; stallreq_* = 0 when the corresponding ce = 0.
- bus_* outputs are registered, loaded on the edge that enters a BUSY state, cleared on the edge that leaves it.
- State machine, 5 states: IDLE, MEM_BUSY, MEM_DONE, IF_BUSY, IF_DISCARD.
  - IF_WAIT is an additional hold state reached from IF_BUSY (see below).
- IDLE:
  - mem_ce=1 and flush=0 -> MEM_BUSY. MEM has priority over IF.
  - else if_ce=1 and flush=0 -> IF_BUSY. bus_we=0, bus_sel=all ones.
- MEM_BUSY, bus_ack=1: capture bus_rdata into mem_rdata (stores capture 0), drop bus_req -> MEM_DONE.
- MEM_DONE: lasts 1 cycle -> IDLE.
- IF_BUSY, bus_ack=1, flush=0:
  - stall[1]=0 -> IDLE; instruction presented combinationally this cycle.
  - stall[1]=1 -> IF_WAIT; instruction held in register.
- IF_BUSY, flush=1, bus_ack=0 -> IF_DISCARD: the bus cycle completes, data is dropped, -> IDLE on ack.
- IF_BUSY, flush=1 and bus_ack=1 in the same cycle: data dropped -> IDLE.
- IF_WAIT: holds until stall[1]=0 -> IDLE. flush in IF_WAIT -> IDLE with held instruction discarded.
- if_inst:
  - bus_rdata when IF_BUSY & bus_ack & !flush;
  - held register in IF_WAIT;
  - else 0.
- stallreq_if = if_ce & !flush & !(IF_BUSY & bus_ack) & state!=IF_WAIT.
- stallreq_mem = mem_ce & state!=MEM_DONE. It also stays asserted while an IF or discard cycle occupies the bus.
- A request never preempts an in-flight bus cycle. The bus holds address/data stable until ack.
- Reset mid-cycle: bus_req drops at that edge; the slave treats this as abort.
- Address/data widths pass through unchanged; no alignment checking (alignment exceptions are raised upstream).

Decomposition:
- Shared package/defines:
  - state encodings (3-bit);
  - RstEnable, ChipEnable, Stop/NoStop;
  - ZeroWord/NOP.
- No sub-module needed. A single always block holds state plus registered bus outputs; combinational logic drives stallreq/if_inst.

Test Plan:
- Fetch, ack latency 2, stall=0, if_addr=0x00000004, bus_rdata=0x3C011234 -> bus_addr=0x4 one cycle after request; stallreq_if high 2 cycles; if_inst=0x3C011234 on ack cycle; state IDLE next.
- Simultaneous if_ce=1, mem_ce=1 load 0x00000100, ack latency 1 -> MEM cycle first; stallreq_if and stallreq_mem high; mem_rdata captured; MEM_DONE one cycle; then fetch issued.
- Fetch acked with stall[1]=1 for 3 cycles -> IF_WAIT; if_inst holds value 3 cycles; stallreq_if=0; IDLE when stall[1]=0.
- flush during IF_BUSY, ack 2 cycles later -> IF_DISCARD; if_inst=0; no new bus_req until ack; next fetch uses new if_addr.
- Store mem_we=1, mem_sel=4'b0011, mem_wdata=0xDEADBEEF -> bus_we=1, bus_sel=0011, bus_wdata=0xDEADBEEF held until ack.
- rst=1 during MEM_BUSY -> next edge: bus_req=0, state IDLE, mem_rdata=0.
